// File: rtl/key_schedule_unit_pkg.sv
// ---------------------------------------------------------------------------
// key_schedule_unit_pkg
// Shared definitions for the AES-128 key expansion engine:
//   - ks_state_t : FSM encodings (KS_IDLE / KS_EXPAND / KS_READY)
//   - AES_NUM_ROUNDS, RCON_INIT, AES_POLY constants
//   - xtime()    : GF(2^8) multiply-by-2 used to advance the round constant
// ---------------------------------------------------------------------------
package key_schedule_unit_pkg;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_t;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT      = 8'h01;
    localparam logic [7:0] AES_POLY       = 8'h1b;

    // Shift left by one; reduce by the AES polynomial when the MSB falls out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] s;
        s = {b[6:0], 1'b0};
        return b[7] ? (s ^ AES_POLY) : s;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (8-bit in, 8-bit out). Shared with the
// encryption datapath.
// Ports:
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0x00 sits in the most significant byte of the constant.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit offset (255-b)*8, and 255-b == ~b for a byte.
    logic [10:0] w_idx;
    assign w_idx  = {~i_byte, 3'b000};
    assign o_byte = SBOX[w_idx +: 8];

endmodule

// File: rtl/key_schedule_unit.sv
// ---------------------------------------------------------------------------
// key_schedule_unit
// Sequential AES-128 key expansion. A key_load pulse latches the cipher key
// as round key 0; round keys 1..10 are then produced one per clock and held
// in an 11-entry register file that the decryption datapath reads by index.
//
// Control: key_load is a single-cycle pulse with no back-pressure; it is
// accepted in every state and always restarts expansion from the new key.
// busy covers the expansion window, key_ready marks a complete key set;
// both are registered and mutually exclusive.
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   key_load   : pulse, latch key and start expansion
//   key        : 128-bit cipher key (key[127:96] is word w0)
//   round_sel  : round key read index 0..10
//   round_key  : combinational read of slot round_sel, 0 when out of range
//   busy       : expansion in progress
//   key_ready  : all round keys valid
//   dbg_state  : current FSM state encoding
// ---------------------------------------------------------------------------
module key_schedule_unit
    import key_schedule_unit_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key,
    input  logic [3:0]   round_sel,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         key_ready,
    output logic [1:0]   dbg_state
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_t    r_state;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [127:0] r_rk [0:NUM_ROUNDS];
    logic         r_busy;
    logic         r_ready;

    logic [127:0] w_prev;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next;

    // Previous round key rk[i-1]; r_round is 1..10 whenever it matters.
    always_comb begin
        w_prev = '0;
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            if (r_round == 4'(k + 1)) begin
                w_prev = r_rk[k];
            end
        end
    end

    assign w_w0 = w_prev[127:96];
    assign w_w1 = w_prev[95:64];
    assign w_w2 = w_prev[63:32];
    assign w_w3 = w_prev[31:0];

    // RotWord: byte0 of w3 moves to the least significant position.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t    = w_sub ^ {r_rcon, 24'h0};
    assign w_n0   = w_w0 ^ w_t;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= KS_IDLE;
            r_round <= 4'd0;
            r_rcon  <= RCON_INIT;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            for (int k = 0; k <= NUM_ROUNDS; k++) begin
                r_rk[k] <= '0;
            end
        end else if (key_load) begin
            // Same restart behaviour from IDLE, mid-expansion and READY.
            r_rk[0] <= key;
            r_round <= 4'd1;
            r_rcon  <= RCON_INIT;
            r_state <= KS_EXPAND;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                KS_EXPAND: begin
                    for (int k = 1; k <= NUM_ROUNDS; k++) begin
                        if (r_round == 4'(k)) begin
                            r_rk[k] <= w_next;
                        end
                    end
                    r_rcon <= xtime(r_rcon);
                    if (r_round == LAST_ROUND) begin
                        r_state <= KS_READY;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    // IDLE and READY hold until the next key_load.
                end
            endcase
        end
    end

    always_comb begin
        round_key = '0;
        for (int k = 0; k <= NUM_ROUNDS; k++) begin
            if (round_sel == 4'(k)) begin
                round_key = r_rk[k];
            end
        end
    end

    assign busy      = r_busy;
    assign key_ready = r_ready;
    assign dbg_state = r_state;

endmodule
